// File: rtl/reg_file_sb.sv
// Multi-port register file with write-through bypass, optional hardwired-zero R0,
// and a per-register reservation scoreboard for issue-stage hazard detection.

module reg_file_sb_entry #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             set,
    output logic [WIDTH-1:0] q,
    output logic             pend
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            pend <= 1'b0;
        end else begin
            if (wr) q <= wdata;
            // a fresh reservation outranks the writeback that retires the old one
            if (set)     pend <= 1'b1;
            else if (wr) pend <= 1'b0;
        end
    end
endmodule

module reg_file_sb #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter bit ZERO_R0 = 1'b1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic             busy_a,
    output logic             busy_b,
    output logic [DEPTH-1:0] pending
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             busy;
    } rd_rsp_t;

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            pend_q;
    logic [DEPTH-1:0]            wsel;
    logic [DEPTH-1:0]            rsel;
    logic [1:0][AW-1:0]          raddr;
    logic                        wr_ok;

    // Address decode doubles as range check: out-of-range or R0 addresses match no entry.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        localparam logic [AW-1:0] IDX = AW'(i);
        if (ZERO_R0 && i == 0) begin : g_zero
            assign regs[i]   = '0;
            assign pend_q[i] = 1'b0;
            assign wsel[i]   = 1'b0;
            assign rsel[i]   = 1'b0;
        end else begin : g_reg
            assign wsel[i] = we && (waddr == IDX);
            assign rsel[i] = rsv_en && (rsv_addr == IDX);
            reg_file_sb_entry #(.WIDTH(WIDTH)) u_ent (
                .clk   (clk),
                .reset (reset),
                .wr    (wsel[i]),
                .wdata (wdata),
                .set   (rsel[i]),
                .q     (regs[i]),
                .pend  (pend_q[i])
            );
        end
    end

    assign wr_ok   = |wsel;
    assign raddr   = {raddr_b, raddr_a};
    assign pending = pend_q;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [WIDTH-1:0] rd;
        logic             pb;
        logic             hit;
        rd_rsp_t          rsp;

        always_comb begin
            rd = '0;
            pb = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (raddr[p] == AW'(i)) begin
                    rd = regs[i];
                    pb = pend_q[i];
                end
            end
            // bypass only on a write that will actually land, so forced-zero reads stay zero
            hit      = wr_ok && (waddr == raddr[p]);
            rsp.data = hit ? wdata : rd;
            rsp.busy = pb && !(we && (waddr == raddr[p]));
        end
    end

    assign rdata_a = g_rd[0].rsp.data;
    assign busy_a  = g_rd[0].rsp.busy;
    assign rdata_b = g_rd[1].rsp.data;
    assign busy_b  = g_rd[1].rsp.busy;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: an 8-entry zero-R0 instance and a 6-entry instance
// exercising out-of-range addresses and reset over pending reservations.

module tb_reg_file_sb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 8-entry instance
    logic        reset, we, rsv_en;
    logic [2:0]  waddr, raddr_a, raddr_b, rsv_addr;
    logic [15:0] wdata, rdata_a, rdata_b;
    logic        busy_a, busy_b;
    logic [7:0]  pending;

    // 6-entry instance
    logic        reset6, we6, rsv_en6;
    logic [2:0]  waddr6, raddr_a6, raddr_b6, rsv_addr6;
    logic [15:0] wdata6, rdata_a6, rdata_b6;
    logic        busy_a6, busy_b6;
    logic [5:0]  pending6;

    reg_file_sb #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b1)) u8 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(busy_a), .busy_b(busy_b),
        .pending(pending)
    );

    reg_file_sb #(.WIDTH(16), .DEPTH(6), .ZERO_R0(1'b1)) u6 (
        .clk(clk), .reset(reset6), .we(we6), .waddr(waddr6), .wdata(wdata6),
        .raddr_a(raddr_a6), .rdata_a(rdata_a6), .raddr_b(raddr_b6), .rdata_b(rdata_b6),
        .rsv_en(rsv_en6), .rsv_addr(rsv_addr6), .busy_a(busy_a6), .busy_b(busy_b6),
        .pending(pending6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; rsv_en = 1'b0;
        waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0; rsv_addr = '0;
        reset6 = 1'b1; we6 = 1'b0; rsv_en6 = 1'b0;
        waddr6 = '0; wdata6 = '0; raddr_a6 = '0; raddr_b6 = '0; rsv_addr6 = '0;
        tick();
        reset = 1'b0; reset6 = 1'b0;

        // post-reset: every address reads zero and nothing is pending
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(7 - i);
            #1;
            chk("rst_rdata_a", 32'(rdata_a), 32'h0);
            chk("rst_rdata_b", 32'(rdata_b), 32'h0);
            chk("rst_busy_a",  32'(busy_a),  32'h0);
            chk("rst_busy_b",  32'(busy_b),  32'h0);
        end
        chk("rst_pending", 32'(pending), 32'h00);

        // write 3 with same-cycle bypass, then from storage
        we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; raddr_a = 3'd3; raddr_b = 3'd1;
        #1;
        chk("bypass_a", 32'(rdata_a), 32'hBEEF);
        chk("bypass_b_other", 32'(rdata_b), 32'h0);
        tick();
        we = 1'b0; raddr_b = 3'd3;
        #1;
        chk("stored_a", 32'(rdata_a), 32'hBEEF);
        chk("stored_b_same_addr", 32'(rdata_b), 32'hBEEF);

        // R0 ignores writes, bypass and reservations
        we = 1'b1; waddr = 3'd0; wdata = 16'h1234; rsv_en = 1'b1; rsv_addr = 3'd0; raddr_a = 3'd0;
        #1;
        chk("r0_bypass", 32'(rdata_a), 32'h0);
        chk("r0_busy_now", 32'(busy_a), 32'h0);
        tick();
        we = 1'b0; rsv_en = 1'b0;
        #1;
        chk("r0_after", 32'(rdata_a), 32'h0);
        chk("r0_busy_after", 32'(busy_a), 32'h0);
        chk("r0_pending", 32'(pending), 32'h00);

        // reserve 5, then writeback clears it and hides the hazard in the same cycle
        rsv_en = 1'b1; rsv_addr = 3'd5;
        tick();
        rsv_en = 1'b0; raddr_b = 3'd5;
        #1;
        chk("rsv5_pending", 32'(pending), 32'h20);
        chk("rsv5_busy_b", 32'(busy_b), 32'h1);
        we = 1'b1; waddr = 3'd5; wdata = 16'h00A5;
        #1;
        chk("wb5_busy_b", 32'(busy_b), 32'h0);
        chk("wb5_rdata_b", 32'(rdata_b), 32'h00A5);
        chk("wb5_pending_still", 32'(pending), 32'h20);
        tick();
        we = 1'b0;
        #1;
        chk("wb5_pending_clr", 32'(pending), 32'h00);
        chk("wb5_stored", 32'(rdata_b), 32'h00A5);
        chk("wb5_busy_after", 32'(busy_b), 32'h0);

        // set beats clear on the same register in the same cycle
        rsv_en = 1'b1; rsv_addr = 3'd2;
        tick();
        rsv_en = 1'b0;
        #1;
        chk("rsv2_pending", 32'(pending), 32'h04);
        we = 1'b1; waddr = 3'd2; wdata = 16'h5A5A; rsv_en = 1'b1; rsv_addr = 3'd2; raddr_a = 3'd2;
        #1;
        chk("rsvwb2_bypass", 32'(rdata_a), 32'h5A5A);
        chk("rsvwb2_busy_hidden", 32'(busy_a), 32'h0);
        tick();
        we = 1'b0; rsv_en = 1'b0;
        #1;
        chk("rsvwb2_pending", 32'(pending), 32'h04);
        chk("rsvwb2_stored", 32'(rdata_a), 32'h5A5A);
        chk("rsvwb2_busy", 32'(busy_a), 32'h1);

        // 6-entry: addr 7 out of range for write, read and reserve
        we6 = 1'b1; waddr6 = 3'd7; wdata6 = 16'hFFFF; raddr_a6 = 3'd7;
        rsv_en6 = 1'b1; rsv_addr6 = 3'd6;
        #1;
        chk("d6_oor_bypass", 32'(rdata_a6), 32'h0);
        tick();
        we6 = 1'b0; rsv_en6 = 1'b0; raddr_b6 = 3'd6;
        #1;
        chk("d6_oor_read", 32'(rdata_a6), 32'h0);
        chk("d6_oor_busy", 32'(busy_b6), 32'h0);
        chk("d6_oor_pending", 32'(pending6), 32'h00);

        we6 = 1'b1; waddr6 = 3'd1; wdata6 = 16'h1111;
        tick();
        waddr6 = 3'd4; wdata6 = 16'h4444;
        tick();
        we6 = 1'b0; raddr_a6 = 3'd1; raddr_b6 = 3'd4;
        #1;
        chk("d6_reg1", 32'(rdata_a6), 32'h1111);
        chk("d6_reg4", 32'(rdata_b6), 32'h4444);
        rsv_en6 = 1'b1; rsv_addr6 = 3'd1;
        tick();
        rsv_en6 = 1'b0;
        #1;
        chk("d6_rsv1_pending", 32'(pending6), 32'h02);
        chk("d6_rsv1_busy", 32'(busy_a6), 32'h1);

        // reset beats a concurrent write and clears pending
        reset6 = 1'b1; we6 = 1'b1; waddr6 = 3'd4; wdata6 = 16'h9999;
        tick();
        reset6 = 1'b0; we6 = 1'b0;
        #1;
        chk("d6_rst_reg1", 32'(rdata_a6), 32'h0);
        chk("d6_rst_reg4", 32'(rdata_b6), 32'h0);
        chk("d6_rst_pending", 32'(pending6), 32'h00);
        chk("d6_rst_busy", 32'(busy_a6), 32'h0);

        // late writeback after reset just writes its data
        we6 = 1'b1; waddr6 = 3'd1; wdata6 = 16'h7777;
        tick();
        we6 = 1'b0;
        #1;
        chk("d6_late_wb", 32'(rdata_a6), 32'h7777);
        chk("d6_late_pending", 32'(pending6), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised multi-port register file with a per-register reservation scoreboard, for the datapath core.
- Supersedes single 16-bit load registers.
- Provides two combinational read ports with write-through bypass, one synchronous write port, and optional hardwired-zero R0.
- The scoreboard marks registers with an outstanding write so issue logic can stall on hazards.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers (≥2; need not be a power of two).
- ZERO_R0, 1, when 1 R0 always reads 0 and ignores writes and reservations.
- AW (localparam), clog2(DEPTH), address width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- raddr_a  input  AW  read port A address.
- rdata_a  output  WIDTH  read port A data (combinational).
- raddr_b  input  AW  read port B address.
- rdata_b  output  WIDTH  read port B data (combinational).
- rsv_en  input  1  reserve request: mark rsv_addr pending.
- rsv_addr  input  AW  register being reserved.
- busy_a  output  1  register at raddr_a has an outstanding write.
- busy_b  output  1  register at raddr_b has an outstanding write.
- pending  output  DEPTH  raw scoreboard vector, bit i = register i pending.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk. On the reset edge all registers become 0 and pending becomes 0. Reset has priority over we and rsv_en in the same cycle.
- Write: on posedge clk with we=1 and waddr<DEPTH, the register takes wdata. The new value is visible through storage from the next cycle.
- Discarded writes: waddr≥DEPTH, or waddr=0 with ZERO_R0=1. Both are silently dropped.
- Read: rdata_x = storage[raddr_x], combinational, zero latency.
- Read bypass: if we=1 and waddr==raddr_x (valid, non-zero-R0), rdata_x = wdata in the same cycle.
- Read forced to 0: raddr_x≥DEPTH, or raddr_x=0 with ZERO_R0=1 (overrides bypass).
- Both ports may read the same address; each resolves independently.
- Scoreboard, per cycle:
  - We clear: we=1 sets pending[waddr] ← 0.
  - Reserve set: rsv_en=1 sets pending[rsv_addr] ← 1.
  - Same address, same cycle, both asserted: the set wins, so the bit ends at 1 (a new reservation follows the old writeback).
  - Ignored: rsv_addr≥DEPTH, or rsv_addr=0 with ZERO_R0=1.
  - A write to a non-pending register is legal; pending stays 0.
- busy_x = pending[raddr_x] AND NOT (we AND waddr==raddr_x). Same-cycle writeback hides the hazard because data is bypassed.
- busy_x = 0 for out-of-range addresses and for zero-R0 reads.
- pending output is registered state only; no bypass is applied.
- No internal FSM beyond storage and scoreboard. All outputs are functions of state and current inputs.
- Reset asserted while entries are pending: everything clears, and a writeback arriving later simply writes its data.
- ZERO_R0=0: R0 behaves as an ordinary register.

Test Plan:
- Reset then read all addresses: rdata_a/b=0, busy_a/b=0, pending=8'h00.
- we=1, waddr=3, wdata=16'hBEEF, raddr_a=3 in the same cycle: rdata_a=16'hBEEF (bypass). Next cycle with we=0: rdata_a=16'hBEEF from storage.
- ZERO_R0=1: we=1, waddr=0, wdata=16'h1234, rsv_en=1, rsv_addr=0: rdata_a(raddr=0)=0 now and after, pending[0]=0, busy_a=0.
- rsv_en on addr 5: next cycle pending=8'h20 and busy_b=1 (raddr_b=5). Then we=1, waddr=5, wdata=16'h00A5: busy_b=0 and rdata_b=16'h00A5 that cycle, pending=8'h00 next cycle.
- Reserve addr 2 → pending[2]=1. Then same cycle we=1, waddr=2, rsv_en=1, rsv_addr=2: register 2 gets wdata and pending[2] stays 1.
- DEPTH=6: write to addr 7 is ignored, and read of addr 7 gives 0. Next, write regs 1 and 4, reserve addr 1, and assert reset alongside we=1, waddr=4: regs 1/4 = 0, pending=0 after the edge.
